// File: rtl/input_router_pkg.sv
// Shared constants, flit type encoding and field offsets for the input router.
// Field offsets are given relative to the full request bundle {flit, vc, valid}.
package input_router_pkg;

  localparam int FLIT_W   = 34;
  localparam int VC_W     = 2;
  localparam int X_W      = 1;
  localparam int Y_W      = 1;
  localparam int PKT_W    = 8;
  localparam int NUM_VC   = 3;
  localparam int NUM_PORT = 5;
  localparam int BUS_W    = FLIT_W + VC_W + 1;

  localparam int FLIT_LO  = VC_W + 1;
  localparam int TYPE_LO  = FLIT_LO + FLIT_W - 2;
  localparam int X_LO     = TYPE_LO - X_W;
  localparam int Y_LO     = X_LO - Y_W;
  localparam int SIZE_LO  = Y_LO - PKT_W;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_SOUTH = 2;
  localparam int PORT_EAST  = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  function automatic logic [NUM_PORT-1:0] port_onehot(input int idx);
    logic [NUM_PORT-1:0] v;
    v = {{(NUM_PORT-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/input_router_xy_route_calc.sv
// Combinational XY dimension-order mapper from head-flit destination to a one-hot port.
// Borrow-based compares keep the logic free of constant comparisons at corner coordinates.
module xy_route_calc
  import input_router_pkg::*;
#(
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0
) (
  input  logic [X_W-1:0]      i_x_dest,
  input  logic [Y_W-1:0]      i_y_dest,
  output logic [NUM_PORT-1:0] o_route
);

  localparam logic [X_W-1:0] HERE_X = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] HERE_Y = Y_W'(ROUTER_Y);

  logic [X_W:0] w_dx;
  logic [Y_W:0] w_dy;

  assign w_dx = {1'b0, i_x_dest} - {1'b0, HERE_X};
  assign w_dy = {1'b0, i_y_dest} - {1'b0, HERE_Y};

  // X first, then Y, then deliver locally.
  always_comb begin
    o_route = {NUM_PORT{1'b0}};
    if (w_dx[X_W]) begin
      o_route = port_onehot(PORT_WEST);
    end else if (|w_dx) begin
      o_route = port_onehot(PORT_EAST);
    end else if (w_dy[Y_W]) begin
      o_route = port_onehot(PORT_NORTH);
    end else if (|w_dy) begin
      o_route = port_onehot(PORT_SOUTH);
    end else begin
      o_route = port_onehot(PORT_LOCAL);
    end
  end

endmodule

// File: rtl/input_router.sv
// Route-computation stage: steers flits to a one-hot output port with per-VC route locking.
// Optional INPUT_ROUTER_ERR_CNT_EN adds err_cnt_o, a saturating count of framing errors.
module input_router
  import input_router_pkg::*;
#(
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [BUS_W-1:0]    fin_req_i,
  output logic                fin_resp_o,
  output logic [BUS_W-1:0]    fout_req_o,
  output logic [NUM_PORT-1:0] fout_dst_o,
  input  logic [NUM_PORT-1:0] fout_resp_i,
  output logic                pkt_err_o
`ifdef INPUT_ROUTER_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt_o
`endif
);

  logic                r_busy  [NUM_VC];
  logic [NUM_PORT-1:0] r_route [NUM_VC];
  logic [PKT_W-1:0]    r_rem   [NUM_VC];
  logic                r_pkt_err;

  logic                w_valid;
  logic [VC_W-1:0]     w_vc;
  flit_type_e          w_type;
  logic [PKT_W-1:0]    w_size;
  logic [NUM_PORT-1:0] w_calc_route;

  logic                w_vc_ok;
  logic                w_busy;
  logic [NUM_PORT-1:0] w_route_st;
  logic [PKT_W-1:0]    w_rem;

  logic                w_fwd;
  logic                w_drop;
  logic                w_tail_err;
  logic [NUM_PORT-1:0] w_sel_route;
  logic                w_xfer;
  logic                w_err;

  assign w_valid = fin_req_i[0];
  assign w_vc    = fin_req_i[VC_W:1];
  assign w_type  = flit_type_e'(fin_req_i[TYPE_LO +: 2]);
  assign w_size  = fin_req_i[SIZE_LO +: PKT_W];

  xy_route_calc #(
    .ROUTER_X (ROUTER_X),
    .ROUTER_Y (ROUTER_Y)
  ) u_xy_route_calc (
    .i_x_dest (fin_req_i[X_LO +: X_W]),
    .i_y_dest (fin_req_i[Y_LO +: Y_W]),
    .o_route  (w_calc_route)
  );

  // Select the context of the VC carried by the current flit; id 3 is not a real VC.
  always_comb begin
    w_vc_ok    = 1'b1;
    w_busy     = 1'b0;
    w_route_st = {NUM_PORT{1'b0}};
    w_rem      = {PKT_W{1'b0}};
    case (w_vc)
      2'd0: begin w_busy = r_busy[0]; w_route_st = r_route[0]; w_rem = r_rem[0]; end
      2'd1: begin w_busy = r_busy[1]; w_route_st = r_route[1]; w_rem = r_rem[1]; end
      2'd2: begin w_busy = r_busy[2]; w_route_st = r_route[2]; w_rem = r_rem[2]; end
      default: w_vc_ok = 1'b0;
    endcase
  end

  // Classify the flit as forwarded (with its route) or dropped against VC framing.
  always_comb begin
    w_fwd       = 1'b0;
    w_drop      = 1'b0;
    w_tail_err  = 1'b0;
    w_sel_route = {NUM_PORT{1'b0}};
    if (!w_valid) begin
      w_drop = 1'b0;
    end else if (!w_vc_ok) begin
      w_drop = 1'b1;
    end else begin
      case (w_type)
        FLIT_HEAD: begin
          if (!w_busy && (w_size >= PKT_W'(2))) begin
            w_fwd       = 1'b1;
            w_sel_route = w_calc_route;
          end else begin
            w_drop = 1'b1;
          end
        end
        FLIT_HEAD_TAIL: begin
          if (!w_busy) begin
            w_fwd       = 1'b1;
            w_sel_route = w_calc_route;
          end else begin
            w_drop = 1'b1;
          end
        end
        FLIT_BODY: begin
          if (w_busy) begin
            w_fwd       = 1'b1;
            w_sel_route = w_route_st;
          end else begin
            w_drop = 1'b1;
          end
        end
        FLIT_TAIL: begin
          if (w_busy) begin
            w_fwd       = 1'b1;
            w_sel_route = w_route_st;
            w_tail_err  = (w_rem != PKT_W'(1));
          end else begin
            w_drop = 1'b1;
          end
        end
        default: w_drop = 1'b1;
      endcase
    end
  end

  // Dropped flits are always accepted so a malformed packet cannot stall the port.
  assign fin_resp_o = (!w_valid || w_drop) ? 1'b1 : |(w_sel_route & fout_resp_i);
  assign fout_dst_o = w_sel_route;
  assign fout_req_o = (|w_sel_route) ? fin_req_i : {BUS_W{1'b0}};
  assign w_xfer     = w_valid & fin_resp_o;
  assign w_err      = w_xfer & (w_drop | w_tail_err);
  assign pkt_err_o  = r_pkt_err;

  // Per-VC route lock and flit countdown, advanced only on an accepted forwarded flit.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        r_busy[i]  <= 1'b0;
        r_route[i] <= {NUM_PORT{1'b0}};
        r_rem[i]   <= {PKT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (w_xfer && w_fwd && (w_vc == VC_W'(i))) begin
          case (w_type)
            FLIT_HEAD: begin
              r_busy[i]  <= 1'b1;
              r_route[i] <= w_calc_route;
              r_rem[i]   <= w_size - PKT_W'(1);
            end
            FLIT_BODY: begin
              r_rem[i] <= (r_rem[i] == {PKT_W{1'b0}}) ? {PKT_W{1'b0}} : r_rem[i] - PKT_W'(1);
            end
            FLIT_TAIL: begin
              r_busy[i] <= 1'b0;
              r_rem[i]  <= {PKT_W{1'b0}};
            end
            default: begin
              r_busy[i] <= r_busy[i];
            end
          endcase
        end
      end
    end
  end

  // Error pulse appears the cycle after the offending transfer.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_pkt_err <= 1'b0;
    end else begin
      r_pkt_err <= w_err;
    end
  end

`ifdef INPUT_ROUTER_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating error counter.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_err_cnt <= 8'd0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_input_router.sv
// Directed self-checking bench for input_router; a second instance at (1,1) covers West/North.
module tb_input_router;

  localparam logic [1:0] H  = 2'b00;
  localparam logic [1:0] B  = 2'b01;
  localparam logic [1:0] T  = 2'b10;
  localparam logic [1:0] HT = 2'b11;
  localparam logic [4:0] PL = 5'b00001;
  localparam logic [4:0] PN = 5'b00010;
  localparam logic [4:0] PS = 5'b00100;
  localparam logic [4:0] PE = 5'b01000;
  localparam logic [4:0] PW = 5'b10000;
  localparam logic [4:0] P0 = 5'b00000;

  logic        clk;
  logic        arst;
  logic [36:0] req;
  logic [4:0]  resp;
  logic        fin_resp, fin_resp2;
  logic [36:0] fout_req, fout_req2;
  logic [4:0]  dst, dst2;
  logic        err, err2;
`ifdef INPUT_ROUTER_ERR_CNT_EN
  logic [7:0]  cnt, cnt2;
`endif

  int checks;
  int failures;

  input_router dut (
    .clk(clk), .arst(arst), .fin_req_i(req), .fin_resp_o(fin_resp),
    .fout_req_o(fout_req), .fout_dst_o(dst), .fout_resp_i(resp), .pkt_err_o(err)
`ifdef INPUT_ROUTER_ERR_CNT_EN
    , .err_cnt_o(cnt)
`endif
  );

  input_router #(.ROUTER_X(1), .ROUTER_Y(1)) dut2 (
    .clk(clk), .arst(arst), .fin_req_i(req), .fin_resp_o(fin_resp2),
    .fout_req_o(fout_req2), .fout_dst_o(dst2), .fout_resp_i(resp), .pkt_err_o(err2)
`ifdef INPUT_ROUTER_ERR_CNT_EN
    , .err_cnt_o(cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] mk(input logic [1:0] t, input logic [1:0] vc,
                                     input logic x, input logic y, input logic [7:0] sz);
    logic [33:0] f;
    f = {t, x, y, sz, 22'h2A5C3};
    return {f, vc, 1'b1};
  endfunction

  task automatic put(input logic [36:0] r, input logic [4:0] p);
    @(negedge clk);
    req  = r;
    resp = p;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b0; req = 37'd0; resp = 5'h1F;
    #3;
    checks++;
    if ({fin_resp, dst, err} !== {1'b1, P0, 1'b0}) begin
      failures++; $display("FAIL reset_outputs: got %b want %b", {fin_resp, dst, err}, {1'b1, P0, 1'b0});
    end
    checks++;
    if (fout_req !== 37'd0) begin
      failures++; $display("FAIL reset_fout_req: got %h want 0", fout_req);
    end
    repeat (2) @(negedge clk);
    arst = 1'b1;
  endtask

  task automatic test_xy_routes();
    put(mk(HT, 2'd0, 1'b0, 1'b1, 8'd1), 5'h1F);
    checks++;
    if ({dst, dst2} !== {PS, PW}) begin
      failures++; $display("FAIL xy_x0y1: got %b want %b", {dst, dst2}, {PS, PW});
    end
    cyc();
    put(mk(HT, 2'd0, 1'b1, 1'b0, 8'd1), 5'h1F);
    checks++;
    if ({dst, dst2} !== {PE, PN}) begin
      failures++; $display("FAIL xy_x1y0: got %b want %b", {dst, dst2}, {PE, PN});
    end
    cyc();
    put(mk(HT, 2'd1, 1'b1, 1'b1, 8'd1), 5'h1F);
    checks++;
    if ({dst, dst2} !== {PE, PL}) begin
      failures++; $display("FAIL xy_x1y1: got %b want %b", {dst, dst2}, {PE, PL});
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL xy_err: got %b want 0", err);
    end
  endtask

  task automatic test_head_tail();
    for (int k = 0; k < 2; k++) begin
      put(mk(HT, 2'd0, 1'b1, 1'b0, 8'd0), 5'h1F);
      checks++;
      if ({fin_resp, dst} !== {1'b1, PE}) begin
        failures++; $display("FAIL ht_east_%0d: got %b want %b", k, {fin_resp, dst}, {1'b1, PE});
      end
      checks++;
      if (fout_req !== req) begin
        failures++; $display("FAIL ht_fout_req_%0d: got %h want %h", k, fout_req, req);
      end
      cyc();
      checks++;
      if (err !== 1'b0) begin
        failures++; $display("FAIL ht_err_%0d: got %b want 0", k, err);
      end
    end
  endtask

  task automatic test_packet_vc1();
    logic [36:0] seq [4];
    logic [4:0]  exp [4];
    seq[0] = mk(H,  2'd1, 1'b0, 1'b0, 8'd3); exp[0] = PL;
    seq[1] = mk(B,  2'd1, 1'b1, 1'b1, 8'd0); exp[1] = PL;
    seq[2] = mk(T,  2'd1, 1'b1, 1'b0, 8'd0); exp[2] = PL;
    seq[3] = mk(HT, 2'd1, 1'b1, 1'b0, 8'd0); exp[3] = PE;
    for (int k = 0; k < 4; k++) begin
      put(seq[k], 5'h1F);
      checks++;
      if ({fin_resp, dst} !== {1'b1, exp[k]}) begin
        failures++; $display("FAIL pkt_vc1_dst_%0d: got %b want %b", k, {fin_resp, dst}, {1'b1, exp[k]});
      end
      cyc();
      checks++;
      if (err !== 1'b0) begin
        failures++; $display("FAIL pkt_vc1_err_%0d: got %b want 0", k, err);
      end
    end
  endtask

  task automatic test_interleave();
    logic [36:0] seq [5];
    logic [4:0]  exp [5];
    seq[0] = mk(H, 2'd0, 1'b1, 1'b0, 8'd3); exp[0] = PE;
    seq[1] = mk(H, 2'd2, 1'b0, 1'b1, 8'd2); exp[1] = PS;
    seq[2] = mk(B, 2'd0, 1'b0, 1'b0, 8'd0); exp[2] = PE;
    seq[3] = mk(T, 2'd2, 1'b1, 1'b0, 8'd0); exp[3] = PS;
    seq[4] = mk(T, 2'd0, 1'b0, 1'b1, 8'd0); exp[4] = PE;
    for (int k = 0; k < 5; k++) begin
      put(seq[k], 5'h1F);
      checks++;
      if (dst !== exp[k]) begin
        failures++; $display("FAIL interleave_dst_%0d: got %b want %b", k, dst, exp[k]);
      end
      cyc();
      checks++;
      if (err !== 1'b0) begin
        failures++; $display("FAIL interleave_err_%0d: got %b want 0", k, err);
      end
    end
  endtask

  task automatic test_backpressure();
    put(mk(H, 2'd0, 1'b1, 1'b0, 8'd2), 5'b10111);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({fin_resp, dst} !== {1'b0, PE}) begin
        failures++; $display("FAIL bp_stall_%0d: got %b want %b", k, {fin_resp, dst}, {1'b0, PE});
      end
      cyc();
      @(negedge clk);
      #1;
    end
    put(mk(H, 2'd0, 1'b1, 1'b0, 8'd2), 5'h1F);
    checks++;
    if ({fin_resp, dst} !== {1'b1, PE}) begin
      failures++; $display("FAIL bp_release: got %b want %b", {fin_resp, dst}, {1'b1, PE});
    end
    cyc();
    put(mk(T, 2'd0, 1'b0, 1'b0, 8'd0), 5'h1F);
    checks++;
    if ({fin_resp, dst} !== {1'b1, PE}) begin
      failures++; $display("FAIL bp_tail: got %b want %b", {fin_resp, dst}, {1'b1, PE});
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL bp_tail_err: got %b want 0", err);
    end
  endtask

  task automatic test_errors();
    put(mk(B, 2'd1, 1'b0, 1'b0, 8'd0), 5'h1F);
    checks++;
    if ({fin_resp, dst, fout_req} !== {1'b1, P0, 37'd0}) begin
      failures++; $display("FAIL err_idle_body_drop: got %b %b %h want 1 00000 0", fin_resp, dst, fout_req);
    end
    cyc();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_idle_body_pulse: got %b want 1", err);
    end
    put(37'd0, 5'h1F);
    cyc();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_pulse_width: got %b want 0", err);
    end
    put(mk(H, 2'd1, 1'b0, 1'b0, 8'd4), 5'h1F);
    cyc();
    put(mk(T, 2'd1, 1'b1, 1'b1, 8'd0), 5'h1F);
    checks++;
    if (dst !== PL) begin
      failures++; $display("FAIL err_early_tail_fwd: got %b want %b", dst, PL);
    end
    cyc();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_early_tail_pulse: got %b want 1", err);
    end
`ifdef INPUT_ROUTER_ERR_CNT_EN
    checks++;
    if (cnt !== 8'd2) begin
      failures++; $display("FAIL err_cnt_two: got %0d want 2", cnt);
    end
`endif
    put(mk(H, 2'd2, 1'b0, 1'b0, 8'd1), 5'h1F);
    checks++;
    if ({fin_resp, dst} !== {1'b1, P0}) begin
      failures++; $display("FAIL err_size1_drop: got %b want %b", {fin_resp, dst}, {1'b1, P0});
    end
    cyc();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_size1_pulse: got %b want 1", err);
    end
    put(mk(H, 2'd2, 1'b0, 1'b0, 8'd2), 5'h1F);
    cyc();
    put(mk(HT, 2'd2, 1'b1, 1'b0, 8'd0), 5'h1F);
    checks++;
    if ({fin_resp, dst} !== {1'b1, P0}) begin
      failures++; $display("FAIL err_head_busy_drop: got %b want %b", {fin_resp, dst}, {1'b1, P0});
    end
    cyc();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_head_busy_pulse: got %b want 1", err);
    end
    put(mk(T, 2'd2, 1'b1, 1'b0, 8'd0), 5'h1F);
    checks++;
    if (dst !== PL) begin
      failures++; $display("FAIL err_busy_kept_tail: got %b want %b", dst, PL);
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_busy_kept_tail_err: got %b want 0", err);
    end
  endtask

  task automatic test_reset_mid();
    put(mk(H, 2'd0, 1'b0, 1'b1, 8'd3), 5'h1F);
    cyc();
    put(mk(B, 2'd0, 1'b0, 1'b0, 8'd0), 5'h1F);
    checks++;
    if (dst !== PS) begin
      failures++; $display("FAIL rst_mid_body_before: got %b want %b", dst, PS);
    end
    cyc();
    put(mk(B, 2'd1, 1'b0, 1'b0, 8'd0), 5'h1F);
    cyc();
    @(negedge clk);
    req  = 37'd0;
    arst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL rst_mid_err_clear: got %b want 0", err);
    end
`ifdef INPUT_ROUTER_ERR_CNT_EN
    checks++;
    if (cnt !== 8'd0) begin
      failures++; $display("FAIL rst_mid_cnt_clear: got %0d want 0", cnt);
    end
`endif
    @(negedge clk);
    arst = 1'b1;
    put(mk(B, 2'd0, 1'b0, 1'b0, 8'd0), 5'h1F);
    checks++;
    if ({fin_resp, dst} !== {1'b1, P0}) begin
      failures++; $display("FAIL rst_mid_body_drop: got %b want %b", {fin_resp, dst}, {1'b1, P0});
    end
    cyc();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL rst_mid_body_pulse: got %b want 1", err);
    end
    put(mk(HT, 2'd0, 1'b0, 1'b0, 8'd0), 5'h1F);
    checks++;
    if (dst !== PL) begin
      failures++; $display("FAIL rst_mid_idle_ht: got %b want %b", dst, PL);
    end
    cyc();
    put(37'd0, 5'h1F);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_xy_routes();
    test_head_tail();
    test_packet_vc1();
    test_interleave();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
